systolic_result_collector: RTL and testbench
============================================

Name: systolic_result_collector

Overview:
- Downstream stage of the 4x4 systolic array. Consumes the skewed per-column partial-sum outputs from the array bottom edge.
- Realigns them into an N x N result matrix buffer and exposes that buffer to the host through a registered read port.
- Sequenced by a start pulse issued by the same controller that enables array shifting. Reports busy/done/error status.

Parameters:
- N, 4, array dimension (rows = columns); result buffer holds N*N words.
- DW, 16, partial-sum width per column.
- LAT, 4, cycles from the start cycle to the first valid result (row 0, column 0) at the array bottom; legal range 1..255.

Ports:
- Clock  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_clear  in  1  synchronous abort-and-clear, highest priority.
- start  in  1  one-cycle pulse that begins a capture run.
- ps_bottom_in  in  N*DW  column c at bits [c*DW+DW-1 : c*DW].
- rd_en  in  1  host read request.
- rd_addr  in  clog2(N*N)  read index = row*N + col.
- rd_data  out  DW  registered read data.
- rd_valid  out  1  high the cycle after an accepted rd_en.
- busy  out  1  run in progress.
- done  out  1  sticky: result matrix complete.
- err  out  1  sticky: start received while busy.

Behaviour:
- Reset (rst_n low, async): state IDLE; buffer all zero; rd_data=0, rd_valid=0, busy=0, done=0, err=0.
- Timing origin: the cycle start is sampled high in IDLE or DONE is cycle 0.
- Capture rule: cell (r,c) samples ps_bottom_in column c at the clock edge ending cycle LAT+r+c, for r,c in 0..N-1. This undoes the array's one-cycle-per-column skew.
- FSM states:
  - IDLE: start -> WAIT (or -> CAPTURE directly if LAT==1).
  - WAIT: count LAT-1 cycles -> CAPTURE.
  - CAPTURE: step counter k = 0..2N-2. Column c writes row k-c when c <= k < c+N. After k = 2N-2 -> DONE.
  - DONE: start -> new run (done cleared in cycle 1).
- busy: high cycles 1..LAT+2N-2.
- done: rises at cycle LAT+2N-1; holds until next accepted start or data_clear.
- Buffer is not zeroed on start. Every cell is overwritten by the run.
- start while busy: ignored, run unaffected, err set (sticky).
- data_clear: immediately forces IDLE, zeroes the buffer, clears rd_data, rd_valid, done and err. A start in the same cycle is ignored. Mid-run clear aborts the run; no partial done is reported.
- Read port: rd_en at cycle t gives rd_data = buf[rd_addr] and rd_valid=1 at cycle t+1.
  - rd_data holds its value when rd_en is low.
  - Reads are legal in any state.
  - A read of a cell written in the same cycle returns the old value (read-before-write).
  - rd_addr >= N*N returns 0.
- Arithmetic: no computation; data is stored bit-exact, DW bits, no sign or width change.
- Reset mid-run: same as the reset values above, takes effect immediately.

Decomposition:
- Shared package (systolic_pkg):
  - constants N_DIM=4, PS_DW=16, default LAT;
  - FSM state encoding (IDLE, WAIT, CAPTURE, DONE);
  - a helper for the read-address width.
- One sub-module, systolic_result_buf: N*N x DW register file with per-column write enable and row index, synchronous clear, one registered read port.
- FSM, counters and skew logic stay in the top block.

Test Plan:
- Basic capture (N=4, LAT=4): drive every column of ps_bottom_in with the cycle number since start. Then read all 16 addresses -> buf[r][c] == 4+r+c (e.g. addr 0 -> 4, addr 15 -> 10). done rises at cycle 11, busy high cycles 1..10.
- Skew check: drive column c with 0xC000|c only on its valid cycles and 0xFFFF otherwise -> every cell == 0xC000|c, no 0xFFFF captured.
- Restart from DONE: second run with values +0x100 -> all cells updated; done low at cycle 1, high again at cycle 11.
- start during busy (at cycle 6): err=1, done timing unchanged; err stays high until data_clear.
- data_clear at cycle 7 of a run: busy=0, done=0, all reads return 0; a following start yields a correct full run.
- Read corner cases: rd_en with rd_addr=3 at capture cycle of (0,3) returns the previous run's value. rd_addr beyond N*N-1 is only reachable when N*N is not a power of two, so with N=4 (16 cells, 4-bit rd_addr) this check runs at N=3: rd_addr=9 -> 0 with rd_valid=1. Async rst_n mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared constants, FSM state encoding and width helpers for the systolic
// array result collector and its result buffer.
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_DIM       = 4;   // array dimension (rows = columns)
    localparam int PS_DW       = 16;  // partial-sum width per column
    localparam int LAT_DEFAULT = 4;   // start cycle to first valid result
    // One counter serves both the WAIT countdown (up to LAT-2 <= 253) and the
    // CAPTURE step index (up to 2N-2), so 8 bits cover both for N <= 128.
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Width of a flat read index row*N+col; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Width of a row index.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_buf.sv
// ----------------------------------------------------------------------------
// systolic_result_buf
// N*N x DW result register file. Each column has its own write enable and
// row index so the skewed column outputs can land in the same clock edge at
// different rows. One registered read port.
//
// Ports:
//   Clock     in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (zeroes everything)
//   clear     in   synchronous clear (zeroes storage and read outputs)
//   wr_en     in   [N]      per-column write enable
//   wr_row    in   [N][RW]  per-column destination row
//   wr_data   in   [N*DW]   column c at bits [c*DW +: DW]
//   rd_en     in   read request
//   rd_addr   in   [AW]     flat index row*N + col
//   rd_data   out  [DW]     registered read data
//   rd_valid  out  high the cycle after rd_en
// ----------------------------------------------------------------------------
module systolic_result_buf
    import systolic_pkg::*;
#(
    parameter  int N  = N_DIM,
    parameter  int DW = PS_DW,
    localparam int AW = addr_w(N),
    localparam int RW = row_w(N)
) (
    input  logic                  Clock,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [N-1:0]          wr_en,
    input  logic [N-1:0][RW-1:0]  wr_row,
    input  logic [N*DW-1:0]       wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_valid
);

    logic [DW-1:0] mem [N*N];
    logic [DW-1:0] rd_mux;

    // Read mux sees the pre-edge contents, so a read of a cell written on the
    // same edge returns the old value. Indices past N*N-1 fall through to 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N * N; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_mux = mem[i];
            end
        end
    end

    // Read handshake: rd_en in cycle t is always accepted; rd_valid is high in
    // cycle t+1 with rd_data. rd_data holds its value while rd_en is low.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N * N; i++) begin
                mem[i] <= '0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N * N; i++) begin
                mem[i] <= '0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (wr_en[c] && wr_row[c] == RW'(r)) begin
                        mem[r*N + c] <= wr_data[c*DW +: DW];
                    end
                end
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: rtl/systolic_result_collector.sv
// ----------------------------------------------------------------------------
// systolic_result_collector
// Bottom-edge collector for an N x N systolic array. Column c of the array
// delivers row r at cycle LAT+r+c after start (one cycle of skew per column);
// this block removes the skew by writing each column into the result buffer
// on its own diagonal schedule, then exposes the matrix through a registered
// read port.
//
// Ports:
//   Clock         in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   data_clear    in   synchronous abort-and-clear, highest priority
//   start         in   one-cycle pulse beginning a capture run
//   ps_bottom_in  in   [N*DW]  column c at bits [c*DW +: DW]
//   rd_en         in   host read request
//   rd_addr       in   [AW]    row*N + col
//   rd_data       out  [DW]    registered read data
//   rd_valid      out  high the cycle after rd_en
//   busy          out  run in progress (cycles 1..LAT+2N-2)
//   done          out  sticky, matrix complete
//   err           out  sticky, start seen while busy
//   dbg_state     out  current FSM state
// ----------------------------------------------------------------------------
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter  int N   = N_DIM,
    parameter  int DW  = PS_DW,
    parameter  int LAT = LAT_DEFAULT,
    localparam int AW  = addr_w(N),
    localparam int RW  = row_w(N)
) (
    input  logic              Clock,
    input  logic              rst_n,
    input  logic              data_clear,
    input  logic              start,
    input  logic [N*DW-1:0]   ps_bottom_in,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output state_t            dbg_state
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [N-1:0]          wr_en;
    logic [N-1:0][RW-1:0]  wr_row;

    assign dbg_state = state;

    // Cycle 0 is the cycle start is sampled. WAIT covers cycles 1..LAT-1 with
    // cnt = cycle-1; CAPTURE covers cycles LAT..LAT+2N-2 with cnt = k.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (data_clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= (LAT == 1) ? ST_CAPTURE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (cnt == CNT_W'(LAT - 2)) begin
                        cnt   <= '0;
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (cnt == CNT_W'(2*N - 2)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Diagonal write schedule: at step k, column c holds row k-c, valid only
    // while 0 <= k-c < N.
    always_comb begin
        wr_en  = '0;
        wr_row = '0;
        for (int c = 0; c < N; c++) begin
            if (state == ST_CAPTURE && int'(cnt) >= c && int'(cnt) < c + N) begin
                wr_en[c]  = 1'b1;
                wr_row[c] = RW'(int'(cnt) - c);
            end
        end
    end

    systolic_result_buf #(
        .N  (N),
        .DW (DW)
    ) u_buf (
        .Clock    (Clock),
        .rst_n    (rst_n),
        .clear    (data_clear),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_data  (ps_bottom_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_systolic_result_collector.sv
// ----------------------------------------------------------------------------
// tb_systolic_result_collector
// Self-checking bench: a 4x4 LAT=4 instance drives most scenarios; a 3x3
// LAT=2 instance covers an out-of-range read address.
// ----------------------------------------------------------------------------
module tb_systolic_result_collector;
    import systolic_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int AW  = addr_w(N);
    localparam int RUN = LAT + 2*N;   // cycles 0..LAT+2N-1 of one run

    localparam int N3   = 3;
    localparam int LAT3 = 2;
    localparam int AW3  = addr_w(N3);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic Clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clock = ~Clock;

    // 4x4 instance
    logic              data_clear   = 1'b0;
    logic              start        = 1'b0;
    logic [N*DW-1:0]   ps_bottom_in = '0;
    logic              rd_en        = 1'b0;
    logic [AW-1:0]     rd_addr      = '0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, busy, done, err;
    state_t            dbg_state;

    // 3x3 instance
    logic              s_data_clear = 1'b0;
    logic              s_start      = 1'b0;
    logic [N3*DW-1:0]  s_ps         = '0;
    logic              s_rd_en      = 1'b0;
    logic [AW3-1:0]    s_rd_addr    = '0;
    logic [DW-1:0]     s_rd_data;
    logic              s_rd_valid, s_busy, s_done, s_err;
    state_t            s_dbg_state;

    systolic_result_collector #(.N(N), .DW(DW), .LAT(LAT)) dut (
        .Clock        (Clock),
        .rst_n        (rst_n),
        .data_clear   (data_clear),
        .start        (start),
        .ps_bottom_in (ps_bottom_in),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    systolic_result_collector #(.N(N3), .DW(DW), .LAT(LAT3)) dut3 (
        .Clock        (Clock),
        .rst_n        (rst_n),
        .data_clear   (s_data_clear),
        .start        (s_start),
        .ps_bottom_in (s_ps),
        .rd_en        (s_rd_en),
        .rd_addr      (s_rd_addr),
        .rd_data      (s_rd_data),
        .rd_valid     (s_rd_valid),
        .busy         (s_busy),
        .done         (s_done),
        .err          (s_err),
        .dbg_state    (s_dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdl  [N*N];        // expected matrix contents
    logic [DW-1:0] hist [RUN][N];     // what each column carried each cycle
    logic          m_done = 1'b0;
    logic          m_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One full capture run starting at cycle 0.
    //   mode 0: every column carries base + cycle number
    //   mode 1: column c carries 0xC000|c on its valid cycles, 0xFFFF otherwise
    //   mode 2: random data
    // dup_at: cycle of an extra start pulse (-1 none); clear_at: cycle of a
    // data_clear pulse (-1 none); probe: read cell (0,N-1) on its capture cycle.
    task automatic run(input int mode, input logic [DW-1:0] base,
                       input int dup_at, input int clear_at, input bit probe);
        logic [DW-1:0] v;
        logic [DW-1:0] probe_exp;
        logic          exp_busy, exp_done, exp_err;
        bit            aborted;
        probe_exp = '0;
        for (int t = 0; t < RUN; t++) begin
            start      = (t == 0) || (t == dup_at);
            data_clear = (t == clear_at);
            rd_en      = probe && (t == LAT + N - 1);
            rd_addr    = AW'(N - 1);
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0:       v = base + DW'(t);
                    1:       v = (t >= LAT + c && t < LAT + c + N) ? (16'hC000 | DW'(c)) : 16'hFFFF;
                    default: v = DW'($urandom_range(0, 16'hFFFF));
                endcase
                ps_bottom_in[c*DW +: DW] = v;
                hist[t][c] = v;
            end
            if (probe && t == LAT + N - 1) probe_exp = mdl[N-1];

            // Expected status during cycle t, straight from the cycle rules.
            aborted  = (clear_at >= 0) && (t > clear_at);
            exp_busy = !aborted && (t >= 1) && (t <= LAT + 2*N - 2);
            exp_done = aborted ? 1'b0 : ((t == 0) ? m_done : (t == LAT + 2*N - 1));
            exp_err  = m_err;
            if (dup_at >= 1 && dup_at <= LAT + 2*N - 2 && t > dup_at) exp_err = 1'b1;
            if (aborted) exp_err = 1'b0;
            check($sformatf("busy c%0d", t), 32'(busy), 32'(exp_busy));
            check($sformatf("done c%0d", t), 32'(done), 32'(exp_done));
            check($sformatf("err c%0d", t),  32'(err),  32'(exp_err));
            if (probe && t == LAT + N) begin
                check("probe rd_valid", 32'(rd_valid), 32'd1);
                check("probe rd_data",  32'(rd_data),  32'(probe_exp));
            end
            step();
        end
        start = 1'b0; data_clear = 1'b0; rd_en = 1'b0;

        if (clear_at >= 0) begin
            for (int i = 0; i < N*N; i++) mdl[i] = '0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mdl[r*N + c] = hist[LAT + r + c][c];
            m_done = 1'b1;
            if (dup_at >= 1 && dup_at <= LAT + 2*N - 2) m_err = 1'b1;
        end
    endtask

    // Read every cell through the scoreboard queue, then check the hold.
    task automatic read_all(input string tag);
        logic [DW-1:0] last;
        last = '0;
        for (int a = 0; a < N*N; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            exp_q.push_back(mdl[a]);
            step();
            check($sformatf("%s valid a%0d", tag, a), 32'(rd_valid), 32'd1);
            last = exp_q.pop_front();
            check($sformatf("%s data a%0d", tag, a), 32'(rd_data), 32'(last));
        end
        rd_en   = 1'b0;
        rd_addr = AW'($urandom_range(0, N*N - 1));
        step();
        check($sformatf("%s idle valid", tag), 32'(rd_valid), 32'd0);
        check($sformatf("%s hold data", tag), 32'(rd_data), 32'(last));
    endtask

    task automatic read_one(input string tag, input int a, input logic [DW-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_en   = 1'b0;
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " data"},  32'(rd_data),  32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [DW-1:0] s_val [N3];

    initial begin
        for (int i = 0; i < N*N; i++) mdl[i] = '0;

        // Reset
        rst_n = 1'b0;
        step(); step();
        check("rst rd_data",  32'(rd_data),   32'd0);
        check("rst rd_valid", 32'(rd_valid),  32'd0);
        check("rst busy",     32'(busy),      32'd0);
        check("rst done",     32'(done),      32'd0);
        check("rst err",      32'(err),       32'd0);
        check("rst state",    32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();
        read_all("zero");

        // Basic capture: cell (r,c) = 4+r+c
        run(0, 16'h0000, -1, -1, 1'b0);
        read_one("basic a0", 0, 16'd4);
        read_one("basic a15", 15, 16'd10);
        read_all("basic");

        // Skew check
        run(1, 16'h0000, -1, -1, 1'b0);
        read_one("skew a5", 5, 16'hC001);
        read_all("skew");

        // Restart from DONE with +0x100, probing (0,3) on its capture cycle
        run(0, 16'h0100, -1, -1, 1'b1);
        read_all("restart");

        // start while busy at cycle 6
        run(2, 16'h0000, 6, -1, 1'b0);
        read_all("dup");
        check("err sticky", 32'(err), 32'd1);

        // Abort with data_clear at cycle 7, then a clean full run
        run(2, 16'h0000, -1, 7, 1'b0);
        read_all("clear");
        run(2, 16'h0000, -1, -1, 1'b0);
        read_all("after clear");

        // start together with data_clear is ignored
        start = 1'b1; data_clear = 1'b1;
        step();
        start = 1'b0; data_clear = 1'b0;
        for (int i = 0; i < N*N; i++) mdl[i] = '0;
        m_done = 1'b0;
        check("clr+start busy",  32'(busy),      32'd0);
        check("clr+start done",  32'(done),      32'd0);
        check("clr+start state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        check("clr+start busy2", 32'(busy), 32'd0);

        // Fill with data, then async reset mid-run
        run(2, 16'h0000, -1, -1, 1'b0);
        rd_en = 1'b1; rd_addr = AW'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < 5; t++) step();
        check("pre-rst busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst busy",     32'(busy),      32'd0);
        check("mid rst done",     32'(done),      32'd0);
        check("mid rst err",      32'(err),       32'd0);
        check("mid rst rd_valid", 32'(rd_valid),  32'd0);
        check("mid rst rd_data",  32'(rd_data),   32'd0);
        check("mid rst state",    32'(dbg_state), 32'(ST_IDLE));
        rd_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < N*N; i++) mdl[i] = '0;
        m_done = 1'b0; m_err = 1'b0;
        read_all("post rst");

        // 3x3 instance: fill with constant per-column data, read past the end
        for (int c = 0; c < N3; c++) begin
            s_val[c] = DW'($urandom_range(1, 16'hFFFF));
            s_ps[c*DW +: DW] = s_val[c];
        end
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int t = 1; t < LAT3 + 2*N3 - 1; t++) step();
        check("n3 done", 32'(s_done), 32'd1);
        s_rd_en = 1'b1; s_rd_addr = AW3'(5);
        step();
        check("n3 a5 valid", 32'(s_rd_valid), 32'd1);
        check("n3 a5 data",  32'(s_rd_data),  32'(s_val[2]));
        s_rd_addr = AW3'(9);
        step();
        check("n3 a9 valid", 32'(s_rd_valid), 32'd1);
        check("n3 a9 data",  32'(s_rd_data),  32'd0);
        s_rd_addr = AW3'(8);
        step();
        check("n3 a8 data",  32'(s_rd_data),  32'(s_val[2]));
        s_rd_addr = AW3'(15);
        step();
        s_rd_en = 1'b0;
        check("n3 a15 data", 32'(s_rd_data),  32'd0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
